game_pixel_gen: RTL and testbench

//  Downstream consumer of the 800x600 VGA timing block. Rebuilds pixel x/y from its HSYNC/VSYNC/rdy outputs.

---
 rtl/game_pixel_gen_pkg.sv | 28 ++
 rtl/game_pixel_gen_if.sv | 25 ++
 rtl/game_pixel_gen_sync_delay.sv | 35 +++
 rtl/game_pixel_gen.sv | 132 +++++++++++++
 tb/tb_game_pixel_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pixel_gen_pkg.sv
// Shared constants, colours and FSM encoding for the game frame renderer.
// Imported by the interface consumers, the delay line and the top.
package game_pixel_gen_pkg;

  localparam int H_VISIBLE   = 800;
  localparam int V_VISIBLE   = 600;
  localparam int SPRITE_SIZE = 32;
  localparam int BORDER_W    = 8;
  localparam int PIPE_LAT    = 2;

  localparam logic [11:0] COL_BG  = 12'h008;
  localparam logic [11:0] COL_BRD = 12'hFFF;
  localparam logic [11:0] COL_SPR = 12'hF80;

  // Largest legal sprite origin keeps the whole square on screen.
  localparam logic [9:0] POS_X_MAX = 10'(H_VISIBLE - SPRITE_SIZE);
  localparam logic [9:0] POS_Y_MAX = 10'(V_VISIBLE - SPRITE_SIZE);

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  function automatic logic [9:0] clamp_pos(input logic [9:0] p, input logic [9:0] lim);
    return (p > lim) ? lim : p;
  endfunction

endpackage

// File: rtl/game_pixel_gen_if.sv
// Bundle of timing inputs, player position and VGA pin outputs.
// master drives timing/position and observes the pins; slave is the renderer.
interface game_pixel_gen_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       rdy_in;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync_out;
  logic       vsync_out;
  logic       frame_start;

  modport master (
    output hsync_in, vsync_in, rdy_in, player_x, player_y,
    input  vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_start
  );

  modport slave (
    input  hsync_in, vsync_in, rdy_in, player_x, player_y,
    output vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_start
  );
endinterface

// File: rtl/game_pixel_gen_sync_delay.sv
// Fixed-depth shift register; every stage resets to RST_VAL so idle-high
// syncs stay inactive while the pipeline refills after reset.
module sync_delay #(
  parameter int               WIDTH   = 2,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             pxl_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      logic [WIDTH-1:0] d_stage;

      if (gi == 0) begin : g_head
        assign d_stage = d;
      end else begin : g_tail
        assign d_stage = g_stage[gi-1].q_reg;
      end

      always_ff @(posedge pxl_clk) begin
        if (!rst_n) q_reg <= RST_VAL;
        else        q_reg <= d_stage;
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/game_pixel_gen.sv
// Renders background, border and a per-frame latched player sprite from
// VGA timing strobes; RGB and syncs leave with a matched 2-cycle latency.
module game_pixel_gen
  import game_pixel_gen_pkg::*;
(
  input logic            pxl_clk,
  input logic            rst_n,
  game_pixel_gen_if.slave vga
);

  localparam logic [10:0] SPR_W     = 11'(SPRITE_SIZE);
  localparam logic [10:0] BRD_LO    = 11'(BORDER_W);
  localparam logic [10:0] X_BRD_HI  = 11'(H_VISIBLE - BORDER_W);
  localparam logic [10:0] Y_BRD_HI  = 11'(V_VISIBLE - BORDER_W);
  localparam logic [9:0]  Y_SAT     = 10'(V_VISIBLE);

  state_t      state_reg, state_next;
  logic        vs_d_reg, rdy_d_reg;
  logic        vs_fall, rdy_fall;
  logic [9:0]  x_cnt_reg, y_cnt_reg;
  logic [9:0]  pos_x_reg, pos_y_reg;
  logic        frame_start_reg;
  logic        hit_spr_reg, hit_brd_reg;
  logic        hit_spr_next, hit_brd_next;
  logic [11:0] rgb_reg, rgb_next;
  logic [10:0] x_ext, y_ext, spr_x_end, spr_y_end;
  logic [1:0]  sync_q;

  assign vs_fall  = vs_d_reg & ~vga.vsync_in;
  assign rdy_fall = rdy_d_reg & ~vga.rdy_in;

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      vs_d_reg  <= 1'b1;
      rdy_d_reg <= 1'b0;
    end else begin
      vs_d_reg  <= vga.vsync_in;
      rdy_d_reg <= vga.rdy_in;
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) state_reg <= WAIT_VSYNC;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_VSYNC: if (vs_fall) state_next = ACTIVE;
      ACTIVE:     state_next = ACTIVE;
      default:    state_next = WAIT_VSYNC;
    endcase
  end

  // Frame start outranks end-of-line so a coincident pair still restarts at (0,0).
  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      x_cnt_reg       <= '0;
      y_cnt_reg       <= '0;
      pos_x_reg       <= '0;
      pos_y_reg       <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= vs_fall;
      if (vs_fall) begin
        x_cnt_reg <= '0;
        y_cnt_reg <= '0;
        pos_x_reg <= clamp_pos(vga.player_x, POS_X_MAX);
        pos_y_reg <= clamp_pos(vga.player_y, POS_Y_MAX);
      end else if (rdy_fall) begin
        x_cnt_reg <= '0;
        if (y_cnt_reg != Y_SAT) y_cnt_reg <= y_cnt_reg + 10'd1;
      end else if (vga.rdy_in) begin
        x_cnt_reg <= x_cnt_reg + 10'd1;
      end
    end
  end

  always_comb begin
    x_ext        = {1'b0, x_cnt_reg};
    y_ext        = {1'b0, y_cnt_reg};
    spr_x_end    = {1'b0, pos_x_reg} + SPR_W;
    spr_y_end    = {1'b0, pos_y_reg} + SPR_W;
    hit_spr_next = vga.rdy_in
                 && (x_ext >= {1'b0, pos_x_reg}) && (x_ext < spr_x_end)
                 && (y_ext >= {1'b0, pos_y_reg}) && (y_ext < spr_y_end);
    hit_brd_next = vga.rdy_in
                 && ((x_ext < BRD_LO) || (x_ext >= X_BRD_HI)
                  || (y_ext < BRD_LO) || (y_ext >= Y_BRD_HI));
  end

  always_comb begin
    rgb_next = 12'h000;
    if (state_reg == ACTIVE && rdy_d_reg) begin
      if (hit_spr_reg)      rgb_next = COL_SPR;
      else if (hit_brd_reg) rgb_next = COL_BRD;
      else                  rgb_next = COL_BG;
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      hit_spr_reg <= 1'b0;
      hit_brd_reg <= 1'b0;
      rgb_reg     <= 12'h000;
    end else begin
      hit_spr_reg <= hit_spr_next;
      hit_brd_reg <= hit_brd_next;
      rgb_reg     <= rgb_next;
    end
  end

  sync_delay #(
    .WIDTH   (2),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (2'b11)
  ) u_sync_delay (
    .pxl_clk (pxl_clk),
    .rst_n   (rst_n),
    .d       ({vga.hsync_in, vga.vsync_in}),
    .q       (sync_q)
  );

  assign vga.vga_r       = rgb_reg[11:8];
  assign vga.vga_g       = rgb_reg[7:4];
  assign vga.vga_b       = rgb_reg[3:0];
  assign vga.hsync_out   = sync_q[1];
  assign vga.vsync_out   = sync_q[0];
  assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_game_pixel_gen.sv
// Drives compressed VGA-style frames (short lines except selected full ones)
// and checks every output cycle against a coordinate-level reference model.
module tb_game_pixel_gen;
  import game_pixel_gen_pkg::*;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        rdy;
    int          x;
    int          y;
  } ent_t;

  logic pxl_clk = 1'b0;
  logic rst_n   = 1'b0;

  game_pixel_gen_if vga ();

  game_pixel_gen dut (
    .pxl_clk (pxl_clk),
    .rst_n   (rst_n),
    .vga     (vga)
  );

  always #5 pxl_clk = ~pxl_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit   active_m = 1'b0;
  bit   prev_vs  = 1'b1;
  bit   fs_exp   = 1'b0;
  int   pos_xm   = 0;
  int   pos_ym   = 0;
  ent_t q0, q1, rst_ent;

  // frame shaping and probe points
  int          full_q[$];
  int          pr_x[$];
  int          pr_y[$];
  logic [11:0] pr_c[$];
  int          rst_line = -1;
  int          chg_line = -1;
  int          chg_x    = 0;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int clamp_i(input int p, input int lim);
    return (p > lim) ? lim : p;
  endfunction

  function automatic logic [11:0] ref_colour(input int x, input int y, input int px, input int py);
    if (x >= px && x < px + SPRITE_SIZE && y >= py && y < py + SPRITE_SIZE) return COL_SPR;
    if (x < BORDER_W || x >= H_VISIBLE - BORDER_W || y < BORDER_W || y >= V_VISIBLE - BORDER_W)
      return COL_BRD;
    return COL_BG;
  endfunction

  task automatic tick(input bit hs, input bit vs, input bit rdy, input int x, input int y);
    ent_t e;
    bit   vsf;
    vga.hsync_in = hs;
    vga.vsync_in = vs;
    vga.rdy_in   = rdy;
    e.hs  = hs;
    e.vs  = vs;
    e.rdy = rdy;
    e.x   = x;
    e.y   = y;
    e.rgb = (active_m && rdy) ? ref_colour(x, y, pos_xm, pos_ym) : 12'h000;
    if (!rst_n) begin
      active_m = 1'b0;
      fs_exp   = 1'b0;
      prev_vs  = 1'b1;
      q0       = rst_ent;
      q1       = rst_ent;
    end else begin
      vsf     = prev_vs && !vs;
      prev_vs = vs;
      fs_exp  = vsf;
      if (vsf) begin
        active_m = 1'b1;
        pos_xm   = clamp_i(int'(vga.player_x), H_VISIBLE - SPRITE_SIZE);
        pos_ym   = clamp_i(int'(vga.player_y), V_VISIBLE - SPRITE_SIZE);
      end
      q1 = q0;
      q0 = e;
    end
    @(posedge pxl_clk);
    #1;
    check_eq("rgb", {vga.vga_r, vga.vga_g, vga.vga_b}, q1.rgb);
    check_eq("hsync_out", 12'(vga.hsync_out), 12'(q1.hs));
    check_eq("vsync_out", 12'(vga.vsync_out), 12'(q1.vs));
    check_eq("frame_start", 12'(vga.frame_start), 12'(fs_exp));
    if (q1.rdy && rst_n) begin
      foreach (pr_x[i])
        if (pr_x[i] == q1.x && pr_y[i] == q1.y)
          check_eq($sformatf("pt_%0d_%0d", q1.x, q1.y), {vga.vga_r, vga.vga_g, vga.vga_b}, pr_c[i]);
    end
  endtask

  task automatic run_line(input int len, input int y);
    for (int x = 0; x < len; x++) tick(1'b1, 1'b1, 1'b1, x, y);
    tick(1'b1, 1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 0, 0);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0, 0);
  endtask

  task automatic run_frame();
    int len;
    for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 0, 0);
    for (int y = 0; y < V_VISIBLE; y++) begin
      if (y == chg_line) vga.player_x = 10'(chg_x);
      if (y == rst_line) begin
        rst_n = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 0, 0);
        rst_n = 1'b1;
      end
      len = $urandom_range(1, 4);
      foreach (full_q[i]) if (full_q[i] == y) len = H_VISIBLE;
      run_line(len, y);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 0, 0);
    full_q.delete();
    pr_x.delete();
    pr_y.delete();
    pr_c.delete();
    rst_line = -1;
    chg_line = -1;
  endtask

  task automatic add_probe(input int x, input int y, input logic [11:0] c);
    pr_x.push_back(x);
    pr_y.push_back(y);
    pr_c.push_back(c);
  endtask

  task automatic random_frame(input bit with_reset);
    int py_c;
    vga.player_x = 10'($urandom_range(0, 1023));
    vga.player_y = 10'($urandom_range(0, 1023));
    py_c = clamp_i(int'(vga.player_y), V_VISIBLE - SPRITE_SIZE);
    full_q.push_back(py_c);
    full_q.push_back(py_c + SPRITE_SIZE - 1);
    for (int i = 0; i < 2; i++) full_q.push_back($urandom_range(0, V_VISIBLE - 1));
    if (with_reset) rst_line = 300;
    run_frame();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_ent.rgb = 12'h000;
    rst_ent.hs  = 1'b1;
    rst_ent.vs  = 1'b1;
    rst_ent.rdy = 1'b0;
    rst_ent.x   = 0;
    rst_ent.y   = 0;
    vga.hsync_in = 1'b1;
    vga.vsync_in = 1'b1;
    vga.rdy_in   = 1'b0;
    vga.player_x = 10'd100;
    vga.player_y = 10'd200;

    // reset held, then visible pixels before any vsync must stay dark
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int y = 0; y < 3; y++) run_line(10, y);

    // sprite at (100,200)
    full_q = '{200, 231, 300};
    add_probe(0, 0, COL_BRD);
    add_probe(100, 200, COL_SPR);
    add_probe(131, 231, COL_SPR);
    add_probe(132, 200, COL_BG);
    add_probe(99, 200, COL_BG);
    add_probe(400, 300, COL_BG);
    run_frame();

    // off-screen request clamps to (768,568)
    vga.player_x = 10'd790;
    vga.player_y = 10'd590;
    full_q = '{568, 580, 599};
    add_probe(799, 599, COL_SPR);
    add_probe(768, 568, COL_SPR);
    add_probe(767, 599, COL_BRD);
    run_frame();

    // position change mid-frame must not tear
    vga.player_x = 10'd300;
    vga.player_y = 10'd100;
    chg_line = 50;
    chg_x    = 600;
    full_q = '{100, 120};
    add_probe(300, 100, COL_SPR);
    add_probe(600, 100, COL_BG);
    run_frame();

    full_q = '{100};
    add_probe(600, 100, COL_SPR);
    add_probe(300, 100, COL_BG);
    run_frame();

    // reset at line 300, then normal frames
    random_frame(1'b1);
    random_frame(1'b0);
    random_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
